dcm_prog_ctrl: RTL and testbench
================================

// Module: dcm_prog_ctrl
// PURPOSE
//  Runtime reprogramming sequencer for one Spartan-6 DCM_CLKGEN. It loads a new
//  CLKFX M/D pair over the PROGCLK/PROGEN/PROGDATA serial port, issues GO, and
//  waits for PROGDONE and LOCKED. Used by the synth to retune the audio master
//  clock (e.g. 48k <-> 44.1k families). PROGCLK is driven from clk.
// PARAMETERS
//  TIMEOUT_CYC  200000  clk cycles allowed in each of WAIT_DONE and WAIT_LOCK before err
//  LOCK_SYNC    2       flop stages on async locked input (>=2)
// PORTS
//  clk        in   1  system clock, also wired to DCM PROGCLK
//  rst        in   1  asynchronous, active-high reset
//  req        in   1  start-programming strobe, sampled in IDLE only
//  mult_m1    in   8  M-1 (M = 2..256), captured on accepted req
//  div_d1     in   8  D-1 (D = 1..256), captured on accepted req
//  busy       out  1  high from accepted req until done/err pulse
//  done       out  1  one-cycle pulse: new M/D active and DCM locked
//  err        out  1  one-cycle pulse: rejected M/D or timeout
//  prog_en    out  1  to DCM PROGEN
//  prog_data  out  1  to DCM PROGDATA
//  prog_done  in   1  from DCM PROGDONE (PROGCLK domain = clk, no sync)
//  locked     in   1  from DCM LOCKED (async, synchronised internally)
// BEHAVIOUR
//  Reset: busy=0, done=0, err=0, prog_en=0, prog_data=0, state IDLE, counters 0.
//  All outputs registered; prog_en/prog_data change on clk rising edge only.
//  States: IDLE, LOAD_D, GAP_D, LOAD_M, GAP_M, GO, WAIT_DONE, WAIT_LOCK.
//  IDLE: req=1 and mult_m1!=0 -> capture M/D, busy=1, go LOAD_D.
//        req=1 and mult_m1==0 (M=1 illegal) -> err pulse next cycle, stay IDLE.
//  LOAD_D: 10 cycles prog_en=1; prog_data = 1,0, then div_d1[0..7] LSB first.
//  GAP_D: 1 cycle prog_en=0, prog_data=0.
//  LOAD_M: 10 cycles prog_en=1; prog_data = 1,1, then mult_m1[0..7] LSB first.
//  GAP_M: 1 cycle prog_en=0.
//  GO: 1 cycle prog_en=1, prog_data=0; then WAIT_DONE.
//  Timing from req cycle 0: LOAD_D cycles 1-10, GAP_D 11, LOAD_M 12-21,
//   GAP_M 22, GO 23, WAIT_DONE from 24.
//  WAIT_DONE: prog_done=1 -> WAIT_LOCK. A prog_done level already high on entry
//   does not count: a 0->1 edge seen after GO is required.
//  WAIT_LOCK: synced locked=1 -> done pulse, busy=0, IDLE.
//  Timeout: a cycle counter restarts on entry to WAIT_DONE and on entry to
//   WAIT_LOCK. If it reaches TIMEOUT_CYC -> err pulse, busy=0, IDLE.
//   done and err are never asserted together.
//  req while busy: ignored, no queueing. req held high re-triggers only once back in IDLE.
//  Captured M/D are frozen for the whole sequence; input changes are ignored.
//  Reset mid-sequence: immediate return to reset values; the DCM keeps its old
//   M/D because GO was never issued. Reset after GO leaves the DCM to finish on
//   its own. The next req restarts the full sequence.
//  Widths: bit counter 4 bits (0..9); timeout counter $clog2(TIMEOUT_CYC+1) bits,
//   saturating.
// STRUCTURE
//  Package dcm_prog_pkg: state enum, CMD_LOAD_D=2'b01 and CMD_LOAD_M=2'b11
//   (sent bit0 first), LOAD_LEN=10.
//  Sub-module dcm_prog_shifter: loads {value[7:0],cmd[1:0]} and shifts it out LSB
//   first with prog_en over 10 cycles, then asserts last. Instantiated once and
//   reused for D and M.
//  Top level: FSM, locked synchroniser, timeout counter.
// TESTING (bench has a DCM_CLKGEN behavioural model or a scoreboard on prog_en/data)
//  1. req, M=128/D=125 (m1=0x7F, d1=0x7C) -> D bits 1,0,0,0,1,1,1,1,1,0;
//     M bits 1,1,1,1,1,1,1,1,1,0; GO at cycle 23; prog_done then locked -> done pulse, busy low.
//  2. req, mult_m1=0 -> err pulse at cycle 1, prog_en never high, busy stays 0.
//  3. prog_done never asserted, TIMEOUT_CYC=100 -> err pulse 100 cycles after
//     WAIT_DONE entry, prog_en=0, IDLE.
//  4. Second req plus changed mult_m1 mid-LOAD_M -> shifted bits match the first capture;
//     exactly one done pulse.
//  5. rst asserted at cycle 15 -> prog_en/busy drop at once, no GO issued; a fresh req
//     then completes normally.
//  6. locked glitches low/high asynchronously during WAIT_LOCK -> done only after
//     LOCK_SYNC+1 cycles of stable high.

Source files
------------

// File: rtl/dcm_prog_pkg.sv
// dcm_prog_pkg: shared FSM states and DCM_CLKGEN serial command constants
package dcm_prog_pkg;
    typedef enum logic [2:0] {
        IDLE, LOAD_D, GAP_D, LOAD_M, GAP_M, GO, WAIT_DONE, WAIT_LOCK
    } state_t;
    localparam logic [1:0] CMD_LOAD_D = 2'b01;
    localparam logic [1:0] CMD_LOAD_M = 2'b11;
    localparam int LOAD_LEN = 10;
endpackage

// File: rtl/dcm_prog_shifter.sv
// dcm_prog_shifter: serialises {value,cmd} LSB first with en, or a one-cycle GO frame
module dcm_prog_shifter
    import dcm_prog_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       go,
    input  logic [7:0] value,
    input  logic [1:0] cmd,
    output logic       en,
    output logic       data,
    output logic       last
);
    logic [9:0] sr;
    logic [3:0] cnt;
    assign data = sr[0];
    assign last = en && cnt == 4'(LOAD_LEN - 1);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr  <= '0;
            en  <= 1'b0;
            cnt <= '0;
        end else if (load) begin
            sr  <= {value, cmd};
            en  <= 1'b1;
            cnt <= '0;
        end else if (go) begin
            sr  <= '0;
            en  <= 1'b1;
            cnt <= 4'(LOAD_LEN - 1);
        end else if (last) begin
            sr  <= '0;
            en  <= 1'b0;
            cnt <= '0;
        end else if (en) begin
            sr  <= sr >> 1;
            cnt <= cnt + 4'd1;
        end
    end
endmodule

// File: rtl/dcm_prog_ctrl.sv
// dcm_prog_ctrl: reprograms a DCM_CLKGEN M/D pair over PROGEN/PROGDATA, issues GO, waits for lock
module dcm_prog_ctrl
    import dcm_prog_pkg::*;
#(
    parameter int TIMEOUT_CYC = 200000,
    parameter int LOCK_SYNC   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic [7:0] mult_m1,
    input  logic [7:0] div_d1,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       prog_en,
    output logic       prog_data,
    input  logic       prog_done,
    input  logic       locked
);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    state_t state, state_n;
    logic [7:0] m_q;
    logic [LOCK_SYNC-1:0] sync;
    logic [TW-1:0] tcnt;
    logic pd_q, accept, load, go, sh_last, lock_s, pd_rise, tmo, done_n, err_n;
    logic [7:0] sh_val;
    logic [1:0] sh_cmd;
    // lock only counts once every synchroniser stage agrees, so short glitches never pass
    assign lock_s  = &sync;
    assign pd_rise = prog_done & ~pd_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync <= '0;
        else sync <= {sync[LOCK_SYNC-2:0], locked};
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
            m_q   <= '0;
            pd_q  <= 1'b0;
            tcnt  <= '0;
        end else begin
            state <= state_n;
            busy  <= state_n != IDLE;
            done  <= done_n;
            err   <= err_n;
            m_q   <= accept ? mult_m1 : m_q;
            pd_q  <= prog_done;
            tcnt  <= state_n != state ? '0 : (tcnt == TW'(TIMEOUT_CYC) ? tcnt : tcnt + 1'b1);
        end
    end
    always_comb begin
        state_n = state;
        case (state)
            IDLE:      state_n = accept ? LOAD_D : IDLE;
            LOAD_D:    state_n = sh_last ? GAP_D : LOAD_D;
            GAP_D:     state_n = LOAD_M;
            LOAD_M:    state_n = sh_last ? GAP_M : LOAD_M;
            GAP_M:     state_n = GO;
            GO:        state_n = WAIT_DONE;
            WAIT_DONE: state_n = pd_rise ? WAIT_LOCK : (tmo ? IDLE : WAIT_DONE);
            WAIT_LOCK: state_n = (lock_s || tmo) ? IDLE : WAIT_LOCK;
            default:   state_n = IDLE;
        endcase
    end
    always_comb begin
        accept = state == IDLE && req && mult_m1 != '0;
        load   = accept || state == GAP_D;
        go     = state == GAP_M;
        sh_val = state == GAP_D ? m_q : div_d1;
        sh_cmd = state == GAP_D ? CMD_LOAD_M : CMD_LOAD_D;
        tmo    = (state == WAIT_DONE || state == WAIT_LOCK) && tcnt == TW'(TIMEOUT_CYC - 1);
        done_n = state == WAIT_LOCK && lock_s;
        err_n  = (state == IDLE && req && mult_m1 == '0)
              || (tmo && !done_n && !(state == WAIT_DONE && pd_rise));
    end
    dcm_prog_shifter u_shifter (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .go    (go),
        .value (sh_val),
        .cmd   (sh_cmd),
        .en    (prog_en),
        .data  (prog_data),
        .last  (sh_last)
    );
endmodule

// File: tb/tb_dcm_prog_ctrl.sv
// tb_dcm_prog_ctrl: directed bench with a prog_en/prog_data scoreboard
module tb_dcm_prog_ctrl;
    localparam int TO = 100;
    logic clk = 1'b0, rst = 1'b1, req = 1'b0, prog_done = 1'b0, locked = 1'b0;
    logic [7:0] mult_m1 = '0, div_d1 = '0;
    logic busy, done, err, prog_en, prog_data;
    int checks = 0, errors = 0, cyc = 0, done_cnt = 0, en_cnt = 0;
    logic [1:0] sb[$];

    dcm_prog_ctrl #(.TIMEOUT_CYC(TO), .LOCK_SYNC(2)) dut (
        .clk(clk), .rst(rst), .req(req), .mult_m1(mult_m1), .div_d1(div_d1),
        .busy(busy), .done(done), .err(err), .prog_en(prog_en), .prog_data(prog_data),
        .prog_done(prog_done), .locked(locked)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic step();
        logic [1:0] e;
        @(posedge clk);
        #1;
        cyc++;
        done_cnt += int'(done);
        en_cnt += int'(prog_en);
        check("done_and_err", 32'(done & err), 0);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("prog_en_data", {30'd0, prog_en, prog_data}, {30'd0, e});
        end
    endtask

    task automatic push_seq(input logic [7:0] m1, input logic [7:0] d1);
        logic [9:0] fd, fm;
        fd = {d1, 2'b01};
        fm = {m1, 2'b11};
        for (int i = 0; i < 10; i++) sb.push_back({1'b1, fd[i]});
        sb.push_back(2'b00);
        for (int i = 0; i < 10; i++) sb.push_back({1'b1, fm[i]});
        sb.push_back(2'b00);
        sb.push_back(2'b10);
        sb.push_back(2'b00);
    endtask

    task automatic start(input logic [7:0] m1, input logic [7:0] d1);
        mult_m1 = m1;
        div_d1 = d1;
        req = 1'b1;
        cyc = 0;
        push_seq(m1, d1);
        step();
        req = 1'b0;
        check("busy_after_req", 32'(busy), 1);
    endtask

    task automatic run_full(input logic [7:0] m1, input logic [7:0] d1);
        start(m1, d1);
        repeat (23) step();
        check("wait_done_en", 32'(prog_en), 0);
        check("wait_done_busy", 32'(busy), 1);
        prog_done = 1'b1;
        step();
        prog_done = 1'b0;
        locked = 1'b1;
        step();
        check("done_early26", 32'(done), 0);
        step();
        check("done_early27", 32'(done), 0);
        step();
        check("done_pulse", 32'(done), 1);
        check("busy_done", 32'(busy), 0);
        step();
        check("done_one_cycle", 32'(done), 0);
        locked = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_outputs", {27'd0, busy, done, err, prog_en, prog_data}, 0);
        rst = 1'b0;
        step();
        check("post_rst_outputs", {27'd0, busy, done, err, prog_en, prog_data}, 0);

        // normal M=128 D=125 sequence
        run_full(8'h7F, 8'h7C);

        // M-1 == 0 is rejected
        mult_m1 = 8'h00;
        div_d1 = 8'h10;
        req = 1'b1;
        cyc = 0;
        en_cnt = 0;
        step();
        req = 1'b0;
        check("reject_err", 32'(err), 1);
        check("reject_busy", 32'(busy), 0);
        step();
        check("reject_err_clear", 32'(err), 0);
        check("reject_prog_en", 32'(en_cnt), 0);

        // prog_done never arrives -> timeout
        start(8'h01, 8'h00);
        repeat (122) step();
        check("to_err_early", 32'(err), 0);
        check("to_busy_early", 32'(busy), 1);
        step();
        check("to_err", 32'(err), 1);
        check("to_busy", 32'(busy), 0);
        check("to_prog_en", 32'(prog_en), 0);
        step();
        check("to_err_clear", 32'(err), 0);

        // inputs and req changed mid-sequence; stale prog_done level ignored
        done_cnt = 0;
        start(8'h3A, 8'h05);
        repeat (14) step();
        mult_m1 = 8'hFF;
        div_d1 = 8'hFF;
        req = 1'b1;
        step();
        req = 1'b0;
        check("mid_busy", 32'(busy), 1);
        repeat (4) step();
        prog_done = 1'b1;
        repeat (8) step();
        check("stale_level_busy", 32'(busy), 1);
        check("stale_level_done", 32'(done), 0);
        prog_done = 1'b0;
        step();
        prog_done = 1'b1;
        step();
        prog_done = 1'b0;
        locked = 1'b1;
        repeat (2) step();
        check("mid_done_early", 32'(done), 0);
        step();
        check("mid_done", 32'(done), 1);
        check("mid_busy_done", 32'(busy), 0);
        step();
        check("mid_done_count", 32'(done_cnt), 1);
        check("mid_idle", 32'(busy), 0);
        locked = 1'b0;

        // reset mid-LOAD_M then a fresh request
        start(8'h10, 8'h02);
        repeat (14) step();
        check("pre_rst_en", 32'(prog_en), 1);
        #2 rst = 1'b1;
        #1;
        check("rst_async", {29'd0, busy, prog_en, prog_data}, 0);
        sb.delete();
        repeat (2) step();
        rst = 1'b0;
        en_cnt = 0;
        repeat (30) step();
        check("rst_no_go", 32'(en_cnt), 0);
        check("rst_idle", 32'(busy), 0);
        run_full(8'h2F, 8'h1F);

        // locked glitches during WAIT_LOCK
        start(8'h5F, 8'h3F);
        repeat (23) step();
        prog_done = 1'b1;
        step();
        prog_done = 1'b0;
        locked = 1'b1;
        step();
        check("glitch_done26", 32'(done), 0);
        #3 locked = 1'b0;
        step();
        check("glitch_done27", 32'(done), 0);
        #2 locked = 1'b1;
        step();
        check("glitch_done28", 32'(done), 0);
        step();
        check("glitch_done29", 32'(done), 0);
        step();
        check("glitch_done30", 32'(done), 1);
        step();
        check("glitch_done_clear", 32'(done), 0);
        locked = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
